hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencing controller for the 5-stage RV32IM core. It sits beside the decode-stage control unit and
//  generates PC/IF-ID/ID-EX write-enables and flushes for three cases: taken-branch flush, load-use bubble, and
//  multi-cycle mul/div EX occupancy. Exports a saturating stall-cycle counter.
// PARAMETERS
//  MUL_CYCLES  4   total EX cycles for MUL/MULH/MULHSU/MULHU (>=2)
//  DIV_CYCLES  33  total EX cycles for DIV/REM/REMU (>=2, <=2**CNT_W)
//  CNT_W       6   width of mul/div down-counter
// PORTS
//  CLK            in   1      clock, all state on rising edge
//  RESET          in   1      synchronous, active-high reset
//  ID_RS1         in   5      rs1 of instruction in ID
//  ID_RS2         in   5      rs2 of instruction in ID
//  ID_USES_RS1    in   1      ID instruction reads rs1
//  ID_USES_RS2    in   1      ID instruction reads rs2
//  EX_VALID       in   1      EX holds a real (non-bubble) instruction
//  EX_RD          in   5      destination register of EX instruction
//  EX_MEM_READ    in   3      MEM_READ code of EX instruction (!=0 means load)
//  EX_ALU_OP      in   5      ALU_OP code of EX instruction
//  BRANCH_TAKEN   in   1      branch/JALR in EX resolved taken
//  PC_WRITE       out  1      PC update enable
//  IF_ID_WRITE    out  1      IF/ID register load enable
//  IF_ID_FLUSH    out  1      IF/ID register clear to NOP
//  ID_EX_WRITE    out  1      ID/EX register load enable
//  ID_EX_FLUSH    out  1      ID/EX register clear to bubble
//  EX_HOLD        out  1      freeze EX/MEM input; EX instruction stays in EX
//  MULDIV_START   out  1      one-cycle pulse: start mul/div unit
//  MULDIV_DONE    out  1      one-cycle pulse: mul/div result valid, EX releasing
//  STALL_CYCLES   out  32     count of cycles with PC_WRITE=0 outside reset, saturating
// BEHAVIOUR
//  Decode: IS_MD = EX_VALID & EX_ALU_OP[4:3]==2'b11 & EX_ALU_OP!=5'b11110; IS_DIV = IS_MD & EX_ALU_OP[2].
//  LAT = IS_DIV ? DIV_CYCLES : MUL_CYCLES.
//  LU_HAZ = EX_VALID & EX_MEM_READ!=0 & EX_RD!=0 & ((ID_USES_RS1&ID_RS1==EX_RD)|(ID_USES_RS2&ID_RS2==EX_RD)).
//  Outputs are combinational from state + inputs. Default (no event): PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=1, rest 0.
//  States: RUN, LDSTALL, MD_WAIT. Reset -> RUN, cnt=0, STALL_CYCLES=0.
//  While RESET=1: PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0, IF_ID_FLUSH=ID_EX_FLUSH=1, all other outputs 0.
//  RUN priority: BRANCH_TAKEN > IS_MD > LU_HAZ.
//   BRANCH_TAKEN&EX_VALID: IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_WRITE=1; stay RUN.
//   IS_MD: MULDIV_START=1, EX_HOLD=1, PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0; cnt<=LAT-2; ->MD_WAIT.
//   LU_HAZ: PC_WRITE=IF_ID_WRITE=0, ID_EX_FLUSH=1 (one bubble); ->LDSTALL.
//  LDSTALL: default outputs, hazard not re-evaluated; BRANCH_TAKEN ignored (EX is the bubble); ->RUN.
//  MD_WAIT: cnt!=0: EX_HOLD=1, PC_WRITE=IF_ID_WRITE=ID_EX_WRITE=0, cnt<=cnt-1.
//   cnt==0: MULDIV_DONE=1, default outputs (EX releases); ->RUN. BRANCH_TAKEN/LU_HAZ ignored in MD_WAIT.
//  Net: mul/div resides in EX exactly LAT cycles (start cycle .. start+LAT-1); front end frozen LAT-1 cycles.
//  Back-to-back mul/div: second is evaluated in RUN the cycle after DONE, restarts normally; no lost cycle
//  beyond its own LAT.
//  STALL_CYCLES: +1 each non-reset cycle with PC_WRITE=0; holds at 32'hFFFF_FFFF.
//  RESET mid-MD_WAIT: abandon; no MULDIV_DONE pulse; next cycle after release in RUN.
//  EX_RD=0 load never stalls; IS_MD with EX_VALID=0 never starts.
// TESTING
//  1 Load x5 in EX, ID add uses rs1=x5 -> 1 cycle PC_WRITE=0, ID_EX_FLUSH=1; next cycle all enables 1; STALL_CYCLES=1.
//  2 Load x0 in EX, ID reads x0 -> no stall; load x5, ID_USES_RS2=0, ID_RS2=x5 -> no stall.
//  3 MUL (11000) in EX, MUL_CYCLES=4 -> START at c0, EX_HOLD c0-c2, DONE+release c3; STALL_CYCLES=3.
//  4 DIV (11100), DIV_CYCLES=33 -> EX_HOLD 32 cycles, DONE at c32; ALU_OP=11110 (LUI fwd) -> no START.
//  5 BRANCH_TAKEN with LU_HAZ same cycle -> both flushes, PC_WRITE=1, no LDSTALL entry.
//  6 RESET asserted at MD_WAIT cnt=10 -> flushes asserted, no DONE; after release state RUN, STALL_CYCLES=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Handshake bundle between the decode/execute pipeline and the hazard controller.
// Signal names follow the pipeline's established port names.
interface hazard_stall_ctrl_if;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic        ID_USES_RS1;
    logic        ID_USES_RS2;
    logic        EX_VALID;
    logic [4:0]  EX_RD;
    logic [2:0]  EX_MEM_READ;
    logic [4:0]  EX_ALU_OP;
    logic        BRANCH_TAKEN;
    logic        PC_WRITE;
    logic        IF_ID_WRITE;
    logic        IF_ID_FLUSH;
    logic        ID_EX_WRITE;
    logic        ID_EX_FLUSH;
    logic        EX_HOLD;
    logic        MULDIV_START;
    logic        MULDIV_DONE;
    logic [31:0] STALL_CYCLES;

    // Pipeline side: supplies ID/EX status, consumes enables and flushes.
    modport master (
        output ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        output EX_VALID, EX_RD, EX_MEM_READ, EX_ALU_OP, BRANCH_TAKEN,
        input  PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH,
        input  EX_HOLD, MULDIV_START, MULDIV_DONE, STALL_CYCLES
    );

    // Controller side.
    modport slave (
        input  ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
        input  EX_VALID, EX_RD, EX_MEM_READ, EX_ALU_OP, BRANCH_TAKEN,
        output PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE, ID_EX_FLUSH,
        output EX_HOLD, MULDIV_START, MULDIV_DONE, STALL_CYCLES
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32IM core: taken-branch flush,
// load-use bubble insertion and multi-cycle mul/div EX occupancy, plus a
// saturating count of front-end stall cycles.
module hazard_stall_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic                CLK,
    input  logic                RESET,
    hazard_stall_ctrl_if.slave  bus
);

    if (MUL_CYCLES < 2) begin : g_bad_mul
        $error("MUL_CYCLES must be at least 2");
    end
    if (DIV_CYCLES < 2 || DIV_CYCLES > (2 ** CNT_W)) begin : g_bad_div
        $error("DIV_CYCLES must be in 2 .. 2**CNT_W");
    end

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LDSTALL,
        ST_MD_WAIT
    } state_e;

    // Counter preload: the start cycle and the release cycle are not counted.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       stall_q, stall_d;

    logic is_md;
    logic is_div;
    logic lu_haz;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_hold;
    logic muldiv_start;
    logic muldiv_done;

    // Decode of the EX instruction class and the load-use hazard.
    always_comb begin
        is_md  = bus.EX_VALID && (bus.EX_ALU_OP[4:3] == 2'b11) && (bus.EX_ALU_OP != 5'b11110);
        is_div = is_md && bus.EX_ALU_OP[2];
        lu_haz = bus.EX_VALID && (bus.EX_MEM_READ != 3'd0) && (bus.EX_RD != 5'd0) &&
                 ((bus.ID_USES_RS1 && (bus.ID_RS1 == bus.EX_RD)) ||
                  (bus.ID_USES_RS2 && (bus.ID_RS2 == bus.EX_RD)));
    end

    // Sequencing: next state, mul/div countdown and pipeline control outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_hold      = 1'b0;
        muldiv_start = 1'b0;
        muldiv_done  = 1'b0;

        if (RESET) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (bus.BRANCH_TAKEN && bus.EX_VALID) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (is_md) begin
                        muldiv_start = 1'b1;
                        ex_hold      = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_write  = 1'b0;
                        cnt_d        = is_div ? DIV_LOAD : MUL_LOAD;
                        state_d      = ST_MD_WAIT;
                    end else if (lu_haz) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        state_d     = ST_LDSTALL;
                    end
                end
                // EX holds the inserted bubble, so nothing is re-evaluated here.
                ST_LDSTALL: begin
                    state_d = ST_RUN;
                end
                ST_MD_WAIT: begin
                    if (cnt_q != '0) begin
                        ex_hold     = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        cnt_d       = cnt_q - CNT_W'(1);
                    end else begin
                        muldiv_done = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating count of cycles the PC is held outside reset.
    always_comb begin
        stall_d = stall_q;
        if (!RESET && !pc_write && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // State registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

    assign bus.PC_WRITE     = pc_write;
    assign bus.IF_ID_WRITE  = if_id_write;
    assign bus.IF_ID_FLUSH  = if_id_flush;
    assign bus.ID_EX_WRITE  = id_ex_write;
    assign bus.ID_EX_FLUSH  = id_ex_flush;
    assign bus.EX_HOLD      = ex_hold;
    assign bus.MULDIV_START = muldiv_start;
    assign bus.MULDIV_DONE  = muldiv_done;
    assign bus.STALL_CYCLES = stall_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, hand-written multi-cycle
// sequences and a randomized run against a cycle-budget reference model.
module tb_hazard_stall_ctrl;

    localparam int MUL_C = 4;
    localparam int DIV_C = 33;

    // Output bundle order: PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_WRITE,
    // ID_EX_FLUSH, EX_HOLD, MULDIV_START, MULDIV_DONE
    localparam logic [7:0] O_RST  = 8'b0010_1000;
    localparam logic [7:0] O_DEF  = 8'b1101_0000;
    localparam logic [7:0] O_BR   = 8'b1111_1000;
    localparam logic [7:0] O_MDS  = 8'b0000_0110;
    localparam logic [7:0] O_MDH  = 8'b0000_0100;
    localparam logic [7:0] O_MDD  = 8'b1101_0001;
    localparam logic [7:0] O_LU   = 8'b0001_1000;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    hazard_stall_ctrl_if bus ();

    hazard_stall_ctrl #(
        .MUL_CYCLES (MUL_C),
        .DIV_CYCLES (DIV_C),
        .CNT_W      (6)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       ev;
        logic [4:0] rd;
        logic [2:0] mr;
        logic [4:0] op;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [14];

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                input logic u2, input logic ev, input logic [4:0] rd,
                                input logic [2:0] mr, input logic [4:0] op, input logic br,
                                input logic [7:0] exp);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.ev = ev;
        v.rd = rd; v.mr = mr; v.op = op; v.br = br; v.exp = exp;
        return v;
    endfunction

    function automatic logic [7:0] outs();
        return {bus.PC_WRITE, bus.IF_ID_WRITE, bus.IF_ID_FLUSH, bus.ID_EX_WRITE,
                bus.ID_EX_FLUSH, bus.EX_HOLD, bus.MULDIV_START, bus.MULDIV_DONE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.ID_RS1 = v.rs1;       bus.ID_RS2 = v.rs2;
        bus.ID_USES_RS1 = v.u1;   bus.ID_USES_RS2 = v.u2;
        bus.EX_VALID = v.ev;      bus.EX_RD = v.rd;
        bus.EX_MEM_READ = v.mr;   bus.EX_ALU_OP = v.op;
        bus.BRANCH_TAKEN = v.br;
    endtask

    task automatic idle();
        drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 5'd0, 1'b0, 8'h00));
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-2 time units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model: outstanding mul/div EX cycles, pending bubble, stall total.
    int     m_md_left;
    bit     m_bubble;
    longint m_stall;

    function automatic logic [7:0] model_outs();
        int  op;
        bit  is_md;
        bit  lu;
        op    = int'(bus.EX_ALU_OP);
        is_md = bus.EX_VALID && op >= 24 && op != 30;
        lu    = bus.EX_VALID && bus.EX_MEM_READ != 0 && bus.EX_RD != 0 &&
                ((bus.ID_USES_RS1 && bus.ID_RS1 == bus.EX_RD) ||
                 (bus.ID_USES_RS2 && bus.ID_RS2 == bus.EX_RD));
        if (rst) return O_RST;
        if (m_md_left == 1) return O_MDD;
        if (m_md_left > 1) return O_MDH;
        if (m_bubble) return O_DEF;
        if (bus.BRANCH_TAKEN && bus.EX_VALID) return O_BR;
        if (is_md) return O_MDS;
        if (lu) return O_LU;
        return O_DEF;
    endfunction

    task automatic model_step(input logic [7:0] o);
        int op;
        op = int'(bus.EX_ALU_OP);
        if (rst) begin
            m_md_left = 0; m_bubble = 0; m_stall = 0;
        end else begin
            if (o[7] == 1'b0 && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (m_md_left > 0) m_md_left--;
            else if (m_bubble) m_bubble = 0;
            else if (o == O_MDS) m_md_left = ((op >= 28) ? DIV_C : MUL_C) - 1;
            else if (o == O_LU) m_bubble = 1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL timeout actual=%0t required=finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e;
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        idle();

        tbl[0]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 3'd2, 5'd0,     0, O_LU);
        tbl[1]  = mk(5'd0, 5'd0, 1, 1, 1, 5'd0, 3'd2, 5'd0,     0, O_DEF);
        tbl[2]  = mk(5'd3, 5'd5, 1, 0, 1, 5'd5, 3'd2, 5'd0,     0, O_DEF);
        tbl[3]  = mk(5'd3, 5'd5, 1, 1, 1, 5'd5, 3'd4, 5'd0,     0, O_LU);
        tbl[4]  = mk(5'd1, 5'd2, 1, 1, 1, 5'd7, 3'd0, 5'b11000, 0, O_MDS);
        tbl[5]  = mk(5'd1, 5'd2, 1, 1, 1, 5'd7, 3'd0, 5'b11100, 0, O_MDS);
        tbl[6]  = mk(5'd1, 5'd2, 1, 1, 1, 5'd7, 3'd0, 5'b11110, 0, O_DEF);
        tbl[7]  = mk(5'd1, 5'd2, 1, 1, 0, 5'd7, 3'd0, 5'b11000, 0, O_DEF);
        tbl[8]  = mk(5'd5, 5'd0, 1, 0, 1, 5'd5, 3'd2, 5'd0,     1, O_BR);
        tbl[9]  = mk(5'd5, 5'd0, 1, 0, 0, 5'd5, 3'd2, 5'd0,     1, O_DEF);
        tbl[10] = mk(5'd1, 5'd2, 1, 1, 1, 5'd7, 3'd0, 5'b11001, 1, O_BR);
        tbl[11] = mk(5'd5, 5'd5, 1, 1, 0, 5'd5, 3'd1, 5'd0,     0, O_DEF);
        tbl[12] = mk(5'd1, 5'd2, 0, 0, 1, 5'd7, 3'd0, 5'b11111, 0, O_MDS);
        tbl[13] = mk(5'd9, 5'd0, 1, 0, 1, 5'd9, 3'd2, 5'b11000, 0, O_MDS);

        // Reset state
        tick();
        #1;
        check("reset_outs", {24'd0, outs()}, {24'd0, O_RST});
        tick();
        check("reset_stall", bus.STALL_CYCLES, 32'd0);

        // Vector table: first cycle from RUN, then stall count after the edge
        for (int i = 0; i < 14; i++) begin
            do_reset();
            drive(tbl[i]);
            #1;
            check($sformatf("vec%0d_outs", i), {24'd0, outs()}, {24'd0, tbl[i].exp});
            tick();
            check($sformatf("vec%0d_stall", i), bus.STALL_CYCLES, (tbl[i].exp[7] ? 32'd0 : 32'd1));
        end

        // Load-use: one bubble, hazard and branch ignored in the stall cycle, then re-evaluated
        do_reset();
        drive(tbl[0]);
        #1;
        check("lu_c0", {24'd0, outs()}, {24'd0, O_LU});
        tick();
        bus.BRANCH_TAKEN = 1'b1;
        #1;
        check("lu_c1_outs", {24'd0, outs()}, {24'd0, O_DEF});
        check("lu_c1_stall", bus.STALL_CYCLES, 32'd1);
        tick();
        bus.BRANCH_TAKEN = 1'b0;
        #1;
        check("lu_c2_reeval", {24'd0, outs()}, {24'd0, O_LU});

        // MUL: start c0, hold c1-c2 (branch/hazard ignored), done c3, back-to-back restart
        do_reset();
        drive(tbl[4]);
        #1;
        check("mul_c0", {24'd0, outs()}, {24'd0, O_MDS});
        for (int c = 1; c < MUL_C; c++) begin
            tick();
            bus.BRANCH_TAKEN = (c == 1);
            bus.EX_MEM_READ  = 3'd2;
            bus.EX_RD        = 5'd1;
            #1;
            check($sformatf("mul_c%0d", c), {24'd0, outs()},
                  {24'd0, (c == MUL_C - 1) ? O_MDD : O_MDH});
        end
        tick();
        drive(tbl[4]);
        #1;
        check("mul_stall", bus.STALL_CYCLES, 32'd3);
        check("mul_b2b_start", {24'd0, outs()}, {24'd0, O_MDS});
        for (int c = 1; c <= MUL_C; c++) tick();
        #1;
        check("mul_b2b_stall", bus.STALL_CYCLES, 32'd6);

        // DIV: hold 32 cycles, done at c32
        do_reset();
        drive(tbl[5]);
        #1;
        check("div_c0", {24'd0, outs()}, {24'd0, O_MDS});
        for (int c = 1; c < DIV_C; c++) begin
            tick();
            #1;
            check($sformatf("div_c%0d", c), {24'd0, outs()},
                  {24'd0, (c == DIV_C - 1) ? O_MDD : O_MDH});
        end
        tick();
        idle();
        #1;
        check("div_stall", bus.STALL_CYCLES, 32'd32);
        check("div_after", {24'd0, outs()}, {24'd0, O_DEF});

        // Reset during MD_WAIT with 10 cycles left: no DONE, RUN after release
        do_reset();
        drive(tbl[5]);
        for (int c = 1; c <= 22; c++) tick();
        #1;
        check("rstmid_pre", {24'd0, outs()}, {24'd0, O_MDH});
        rst = 1'b1;
        #1;
        check("rstmid_outs", {24'd0, outs()}, {24'd0, O_RST});
        tick();
        rst = 1'b0;
        idle();
        #1;
        check("rstmid_run", {24'd0, outs()}, {24'd0, O_DEF});
        check("rstmid_stall", bus.STALL_CYCLES, 32'd0);
        drive(tbl[4]);
        #1;
        check("rstmid_restart", {24'd0, outs()}, {24'd0, O_MDS});

        // Randomized run against the reference model
        do_reset();
        m_md_left = 0;
        m_bubble  = 0;
        m_stall   = 0;
        for (int c = 0; c < 3000; c++) begin
            int pick;
            rst              = ($urandom_range(0, 99) == 0);
            bus.ID_RS1       = 5'($urandom_range(0, 3));
            bus.ID_RS2       = 5'($urandom_range(0, 3));
            bus.ID_USES_RS1  = 1'($urandom_range(0, 1));
            bus.ID_USES_RS2  = 1'($urandom_range(0, 1));
            bus.EX_VALID     = ($urandom_range(0, 9) != 0);
            bus.EX_RD        = 5'($urandom_range(0, 3));
            bus.EX_MEM_READ  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            bus.BRANCH_TAKEN = ($urandom_range(0, 7) == 0);
            pick = int'($urandom_range(0, 19));
            case (pick)
                0: bus.EX_ALU_OP = 5'b11000;
                1: bus.EX_ALU_OP = 5'b11100;
                2, 3: bus.EX_ALU_OP = 5'b11110;
                4: bus.EX_ALU_OP = 5'b11111;
                default: bus.EX_ALU_OP = 5'($urandom_range(0, 23));
            endcase
            #1;
            e = model_outs();
            check($sformatf("rand%0d_outs", c), {24'd0, outs()}, {24'd0, e});
            check($sformatf("rand%0d_stall", c), bus.STALL_CYCLES, m_stall[31:0]);
            model_step(e);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
